// File: rtl/sme_pkg.sv
// Shared definitions for the SME host driver: FSM states, buffer depths and
// the special characters understood by the string-matching engine.
package sme_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_STR,
        ST_SEND_PAT,
        ST_WAIT,
        ST_GAP
    } sme_state_e;

    localparam int unsigned STR_DEPTH = 32;
    localparam int unsigned PAT_DEPTH = 8;

    localparam logic [7:0] CARET  = 8'h5E;
    localparam logic [7:0] DOLLAR = 8'h24;
    localparam logic [7:0] DOT    = 8'h2E;
    localparam logic [7:0] STAR   = 8'h2A;
    localparam logic [7:0] SPACE  = 8'h20;

endpackage

// File: rtl/sme_byte_buf.sv
// Byte buffer with append-only write port, saturating length counter,
// synchronous clear and a combinational read port.
module sme_byte_buf #(
    parameter int unsigned DEPTH = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic                         clr,
    input  logic [7:0]                   wr_data,
    input  logic [$clog2(DEPTH+1)-1:0]   rd_addr,
    output logic [7:0]                   rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   len
);

    localparam int unsigned   LW   = $clog2(DEPTH + 1);
    localparam int unsigned   AW   = $clog2(DEPTH);
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    logic [7:0] mem [DEPTH];
    logic       wr_ok;

    assign wr_ok = wr_en && (len != FULL);

    // Contents are deliberately not reset; only the length is.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[len[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len <= '0;
        end else if (clr) begin
            len <= '0;
        end else if (wr_ok) begin
            len <= len + 1'b1;
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_addr < FULL) begin
            rd_data = mem[rd_addr[AW-1:0]];
        end
    end

endmodule

// File: rtl/sme_driver.sv
// Host-side driver for the string-matching engine: buffers a string and a
// pattern, streams them to the engine, then captures its result or times out.
module sme_driver
    import sme_pkg::*;
#(
    parameter int unsigned STR_DEPTH = sme_pkg::STR_DEPTH,
    parameter int unsigned PAT_DEPTH = sme_pkg::PAT_DEPTH,
    parameter int unsigned TIMEOUT   = 1023
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            ld_en,
    input  logic                            ld_sel,
    input  logic [7:0]                      ld_data,
    input  logic                            start,
    input  logic                            keep_string,
    output logic                            busy,
    output logic [7:0]                      chardata,
    output logic                            isstring,
    output logic                            ispattern,
    input  logic                            valid,
    input  logic                            match,
    input  logic [5:0]                      match_index,
    output logic                            done,
    output logic                            res_match,
    output logic [5:0]                      res_index,
    output logic                            timeout,
    output logic [$clog2(STR_DEPTH+1)-1:0]  str_len,
    output logic [$clog2(PAT_DEPTH+1)-1:0]  pat_len
);

    localparam int unsigned   SLW    = $clog2(STR_DEPTH + 1);
    localparam int unsigned   PLW    = $clog2(PAT_DEPTH + 1);
    localparam int unsigned   TW     = $clog2(TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    sme_state_e     state;
    logic [SLW-1:0] sptr;
    logic [PLW-1:0] pptr;
    logic [TW-1:0]  tcnt;
    logic [7:0]     str_rd;
    logic [7:0]     pat_rd;
    logic           idle;
    logic           start_ok;
    logic           send_str;
    logic           buf_wr;
    logic           clr;

    assign idle     = (state == ST_IDLE);
    assign start_ok = idle && start && (pat_len != '0) && ((str_len != '0) || keep_string);
    assign send_str = !keep_string && (str_len != '0);
    assign buf_wr   = idle && ld_en && !start;
    assign clr      = (state == ST_GAP);

    sme_byte_buf #(.DEPTH(STR_DEPTH)) u_str_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (buf_wr && !ld_sel),
        .clr     (clr),
        .wr_data (ld_data),
        .rd_addr (sptr),
        .rd_data (str_rd),
        .len     (str_len)
    );

    sme_byte_buf #(.DEPTH(PAT_DEPTH)) u_pat_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (buf_wr && ld_sel),
        .clr     (clr),
        .wr_data (ld_data),
        .rd_addr (pptr),
        .rd_data (pat_rd),
        .len     (pat_len)
    );

    // Outputs are registered, so each state presents the byte at the current
    // pointer and advances it; pointers idle at zero so byte 0 is ready on start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            sptr      <= '0;
            pptr      <= '0;
            tcnt      <= '0;
            busy      <= 1'b0;
            chardata  <= '0;
            isstring  <= 1'b0;
            ispattern <= 1'b0;
            done      <= 1'b0;
            res_match <= 1'b0;
            res_index <= '0;
            timeout   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        busy <= 1'b1;
                        tcnt <= '0;
                        if (send_str) begin
                            state    <= ST_SEND_STR;
                            chardata <= str_rd;
                            isstring <= 1'b1;
                            sptr     <= sptr + 1'b1;
                        end else begin
                            state     <= ST_SEND_PAT;
                            chardata  <= pat_rd;
                            ispattern <= 1'b1;
                            pptr      <= pptr + 1'b1;
                        end
                    end
                end
                ST_SEND_STR: begin
                    if (sptr < str_len) begin
                        chardata <= str_rd;
                        sptr     <= sptr + 1'b1;
                    end else begin
                        // Pattern byte 0 follows immediately: an idle cycle ends input.
                        state     <= ST_SEND_PAT;
                        sptr      <= '0;
                        isstring  <= 1'b0;
                        ispattern <= 1'b1;
                        chardata  <= pat_rd;
                        pptr      <= pptr + 1'b1;
                    end
                end
                ST_SEND_PAT: begin
                    if (pptr < pat_len) begin
                        chardata <= pat_rd;
                        pptr     <= pptr + 1'b1;
                    end else begin
                        state     <= ST_WAIT;
                        pptr      <= '0;
                        ispattern <= 1'b0;
                        chardata  <= '0;
                        tcnt      <= '0;
                    end
                end
                ST_WAIT: begin
                    // done high marks the cycle after capture; leave on it.
                    if (done) begin
                        state <= ST_GAP;
                    end else if (valid) begin
                        res_match <= match;
                        res_index <= match_index;
                        timeout   <= 1'b0;
                        done      <= 1'b1;
                    end else if (tcnt == T_LAST) begin
                        res_match <= 1'b0;
                        res_index <= '0;
                        timeout   <= 1'b1;
                        done      <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sme_driver.sv
// Scoreboard bench for sme_driver with a behavioural SME that answers after
// a programmable latency (or never, to exercise the timeout).
module tb_sme_driver;
    import sme_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ld_en = 1'b0;
    logic       ld_sel = 1'b0;
    logic [7:0] ld_data = '0;
    logic       start = 1'b0;
    logic       keep_string = 1'b0;
    logic       valid = 1'b0;
    logic       match = 1'b0;
    logic [5:0] match_index = '0;
    logic       busy, isstring, ispattern, done, res_match, timeout;
    logic [7:0] chardata;
    logic [5:0] res_index;
    logic [5:0] str_len;
    logic [3:0] pat_len;

    sme_driver #(.STR_DEPTH(32), .PAT_DEPTH(8), .TIMEOUT(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .ld_en       (ld_en),
        .ld_sel      (ld_sel),
        .ld_data     (ld_data),
        .start       (start),
        .keep_string (keep_string),
        .busy        (busy),
        .chardata    (chardata),
        .isstring    (isstring),
        .ispattern   (ispattern),
        .valid       (valid),
        .match       (match),
        .match_index (match_index),
        .done        (done),
        .res_match   (res_match),
        .res_index   (res_index),
        .timeout     (timeout),
        .str_len     (str_len),
        .pat_len     (pat_len)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [9:0] exp_bytes[$];
    logic [7:0] exp_res[$];
    int bursts, first_act_cyc, wait_cyc, valid_cyc, done_cyc, start_cyc;

    logic       model_respond = 1'b1;
    int         model_lat = 0;
    logic       model_match = 1'b0;
    logic [5:0] model_idx = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Stream scoreboard: every active byte must match the next expected entry.
    logic prev_act = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            if (isstring || ispattern) begin
                if (!prev_act) begin
                    bursts++;
                    first_act_cyc = cyc;
                end
                if (exp_bytes.size() == 0)
                    check("stream_extra", {isstring, ispattern, chardata}, 10'h000);
                else
                    check("stream", {isstring, ispattern, chardata}, exp_bytes.pop_front());
            end else if (busy) begin
                check("wait_chardata", chardata, 8'h00);
            end
        end
        prev_act = reset && (isstring || ispattern);
    end

    // Behavioural engine: end of input is the first idle cycle after activity.
    logic m_prev = 1'b0;
    logic m_pend = 1'b0;
    int   m_left = 0;
    initial begin
        forever begin
            @(negedge clk);
            valid = 1'b0;
            if (!reset) begin
                m_prev = 1'b0;
                m_pend = 1'b0;
            end else begin
                if (m_prev && !(isstring || ispattern)) begin
                    wait_cyc = cyc;
                    m_pend   = model_respond;
                    m_left   = model_lat;
                end
                if (m_pend) begin
                    if (m_left == 0) begin
                        valid       = 1'b1;
                        match       = model_match;
                        match_index = model_idx;
                        valid_cyc   = cyc;
                        m_pend      = 1'b0;
                    end else begin
                        m_left--;
                    end
                end
                m_prev = isstring || ispattern;
            end
        end
    end

    task automatic ld(input logic sel, input logic [7:0] d);
        ld_en   = 1'b1;
        ld_sel  = sel;
        ld_data = d;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    task automatic go(input logic keep);
        bursts      = 0;
        start       = 1'b1;
        keep_string = keep;
        @(negedge clk);
        start       = 1'b0;
        keep_string = 1'b0;
        start_cyc   = cyc;
    endtask

    task automatic wait_done(input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen     = 1;
                done_cyc = cyc;
            end
        end
        if (!seen) begin
            check("done_seen", 32'd0, 32'd1);
        end else begin
            if (exp_res.size() == 0)
                check("result_unexpected", {res_match, res_index, timeout}, 32'hFFFF_FFFF);
            else
                check("result", {res_match, res_index, timeout}, exp_res.pop_front());
            @(negedge clk);
            check("done_pulse", done, 1'b0);
            check("busy_gap", busy, 1'b1);
            @(negedge clk);
            check("busy_idle", busy, 1'b0);
            check("lens_cleared", {str_len, pat_len}, 10'd0);
        end
    endtask

    logic [7:0] s_basic [5] = '{8'h61, 8'h62, SPACE, 8'h63, 8'h64};
    logic [7:0] pat9    [9] = '{CARET, 8'h61, DOT, STAR, 8'h62, SPACE, 8'h63, DOLLAR, 8'h7A};

    initial begin
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_stream", {isstring, ispattern, chardata}, 10'd0);
        check("rst_result", {done, res_match, res_index, timeout}, 9'd0);
        check("rst_lens", {str_len, pat_len}, 10'd0);
        #2 reset = 1'b1;
        @(negedge clk);

        // Start with an empty pattern buffer is ignored.
        ld(1'b0, 8'h61);
        go(1'b0);
        check("guard_nopat_busy", busy, 1'b0);
        check("guard_nopat_len", str_len, 6'd1);

        // Basic job "ab cd" / "cd" (first byte already loaded above).
        for (int i = 1; i < 5; i++) ld(1'b0, s_basic[i]);
        ld(1'b1, 8'h63);
        ld(1'b1, 8'h64);
        check("basic_lens", {str_len, pat_len}, {6'd5, 4'd2});
        for (int i = 0; i < 5; i++) exp_bytes.push_back({2'b10, s_basic[i]});
        exp_bytes.push_back({2'b01, 8'h63});
        exp_bytes.push_back({2'b01, 8'h64});
        exp_res.push_back({1'b1, 6'd3, 1'b0});
        model_lat = 2; model_match = 1'b1; model_idx = 6'd3;
        go(1'b0);
        ld(1'b0, 8'hEE);
        ld(1'b1, 8'hEE);
        ld(1'b0, 8'hEE);
        check("busy_ld_lens", {str_len, pat_len}, {6'd5, 4'd2});
        check("busy_mid", busy, 1'b1);
        wait_done(40);
        check("basic_bursts", bursts, 1);
        check("basic_first_byte", first_act_cyc, start_cyc);
        check("basic_wait_entry", wait_cyc, start_cyc + 7);
        check("basic_valid_to_done", done_cyc, valid_cyc + 1);

        // Keep-string job: pattern only; start without keep_string is refused.
        ld(1'b1, 8'h61);
        ld(1'b1, 8'h62);
        go(1'b0);
        check("guard_nostr_busy", busy, 1'b0);
        exp_bytes.push_back({2'b01, 8'h61});
        exp_bytes.push_back({2'b01, 8'h62});
        exp_res.push_back({1'b1, 6'd5, 1'b0});
        model_lat = 3; model_match = 1'b1; model_idx = 6'd5;
        go(1'b1);
        wait_done(40);
        check("keep_bursts", bursts, 1);
        check("keep_first_byte", first_act_cyc, start_cyc);
        check("keep_wait_entry", wait_cyc, start_cyc + 2);

        // Timeout: engine stays silent.
        ld(1'b0, 8'h78);
        ld(1'b1, 8'h79);
        exp_bytes.push_back({2'b10, 8'h78});
        exp_bytes.push_back({2'b01, 8'h79});
        exp_res.push_back({1'b0, 6'd0, 1'b1});
        model_respond = 1'b0;
        go(1'b0);
        wait_done(60);
        check("timeout_latency", done_cyc - wait_cyc, 16);
        model_respond = 1'b1;
        repeat (3) @(negedge clk);
        check("timeout_hold", {res_match, res_index, timeout}, 8'h01);

        // Overflow: extra writes are dropped, lengths saturate.
        for (int i = 0; i < 33; i++) begin
            ld(1'b0, 8'h41 + 8'(i));
            if (i < 32) exp_bytes.push_back({2'b10, 8'h41 + 8'(i)});
        end
        for (int i = 0; i < 9; i++) begin
            ld(1'b1, pat9[i]);
            if (i < 8) exp_bytes.push_back({2'b01, pat9[i]});
        end
        check("ovf_lens", {str_len, pat_len}, {6'd32, 4'd8});
        exp_res.push_back({1'b0, 6'd42, 1'b0});
        model_lat = 0; model_match = 1'b0; model_idx = 6'd42;
        go(1'b0);
        wait_done(80);
        check("ovf_bursts", bursts, 1);
        check("ovf_wait_entry", wait_cyc, start_cyc + 40);

        // Reset mid-stream.
        ld(1'b0, 8'h70); ld(1'b0, 8'h71); ld(1'b0, 8'h72); ld(1'b0, 8'h73);
        ld(1'b1, 8'h7A);
        exp_bytes.push_back({2'b10, 8'h70});
        exp_bytes.push_back({2'b10, 8'h71});
        go(1'b0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("rstmid_stream", {isstring, ispattern, chardata}, 10'd0);
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_lens", {str_len, pat_len}, 10'd0);
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        check("rstmid_stream_left", exp_bytes.size(), 0);

        // Fresh job after reset.
        ld(1'b0, 8'h68); ld(1'b0, 8'h69);
        ld(1'b1, 8'h69);
        exp_bytes.push_back({2'b10, 8'h68});
        exp_bytes.push_back({2'b10, 8'h69});
        exp_bytes.push_back({2'b01, 8'h69});
        exp_res.push_back({1'b1, 6'd1, 1'b0});
        model_lat = 1; model_match = 1'b1; model_idx = 6'd1;
        go(1'b0);
        wait_done(40);
        check("post_rst_wait_entry", wait_cyc, start_cyc + 3);
        check("final_stream_left", exp_bytes.size(), 0);
        check("final_result_left", exp_res.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1);
    end

endmodule

// File: doc/sme_driver.md
# sme_driver

Host-side driver for the string-matching engine (SME). Buffers one string and one pattern loaded byte-by-byte by a host or testbench. On `start`, streams them onto the SME input port using the `chardata`/`isstring`/`ispattern` protocol, then waits for the engine's `valid`. It captures `match`/`match_index` into a result register, signals `done`, and enforces a timeout if the engine never responds.

## Interface
- STR_DEPTH, 32, string buffer depth in bytes (max string length)
- PAT_DEPTH, 8, pattern buffer depth in bytes
- TIMEOUT, 1023, WAIT-state cycles before the job is abandoned (≥2)

- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low
- ld_en  in  1  load strobe, one byte per cycle
- ld_sel  in  1  0 = string buffer, 1 = pattern buffer
- ld_data  in  8  byte to load
- start  in  1  launch job, single-cycle pulse
- keep_string  in  1  sampled with `start`; 1 = send no string bytes (engine reuses its stored string)
- busy  out  1  job in progress
- chardata  out  8  byte to SME
- isstring  out  1  `chardata` is a string byte
- ispattern  out  1  `chardata` is a pattern byte
- valid  in  1  SME result strobe
- match  in  1  SME match flag
- match_index  in  6  SME match position
- done  out  1  one-cycle result pulse
- res_match  out  1  captured match (0 on timeout)
- res_index  out  6  captured index (0 on timeout)
- timeout  out  1  set with `done` when no `valid` arrived
- str_len  out  6  bytes held in string buffer (0..32)
- pat_len  out  4  bytes held in pattern buffer (0..8)

## Operation
- **Loading:** only in IDLE. `ld_en` writes `ld_data` at the selected buffer's length, then increments that length. Writes when length == depth are dropped; length saturates.
- **Ignored inputs:** `ld_en` while busy is ignored. `start` and `ld_en` in the same cycle: start wins and the write is dropped.
- **Start accepted** only if IDLE, `pat_len` ≥ 1, and (`str_len` ≥ 1 or `keep_string`). Otherwise it is ignored with no `done`.
- **States:** IDLE → SEND_STR → SEND_PAT → WAIT → GAP → IDLE.
  - SEND_STR is skipped when `keep_string`=1 or `str_len`=0.
  - SEND_STR: bytes 0..str_len-1 in order, `isstring`=1.
  - SEND_PAT: bytes 0..pat_len-1, `ispattern`=1. It follows the last string byte with no idle gap, because the engine treats any idle cycle as end of input.
  - WAIT: `isstring`=`ispattern`=0, `chardata`=0, timeout counter runs.
- **Result capture:** in WAIT, when `valid`=1, `match`/`match_index` are captured; the next cycle gives `done`=1, `timeout`=0, and the state moves to GAP.
- **Timeout:** the counter reaches TIMEOUT-1 without `valid` → `done`=1, `timeout`=1, `res_*`=0, then GAP.
- **GAP:** one idle cycle that lets the engine return to its input state. It clears `str_len` and `pat_len` to 0, then → IDLE.
- **Output holding:** `res_match`, `res_index`, `timeout` hold until the next `done`. `valid` outside WAIT is ignored.
- **Registers:** all outputs are registered. Counters are sized to their depth, with no wrap: the string pointer is 6 bits, the pattern pointer 4 bits, the timeout counter $clog2(TIMEOUT).

## Timing
- `start` accepted at edge t:
  - first string byte is valid from t+1; string occupies cycles t+1..t+S;
  - pattern occupies t+S+1..t+S+P (with `keep_string`: t+1..t+P);
  - WAIT is entered at t+S+P+1.
- `busy` rises at t+1 and falls on the edge leaving GAP.
- `valid` sampled at edge v → `done` high cycle v+1, GAP cycle v+2, IDLE v+3. The earliest next accepted `start` is at edge v+3.
- **Reset:** while `reset`=0, all outputs are 0, lengths are 0 and state is IDLE, asynchronously, including mid-stream. Buffer contents are not reset.

## Structure
- Package `sme_pkg`: state enum, `STR_DEPTH`/`PAT_DEPTH` defaults, and character constants shared with the engine: CARET 8'h5E, DOLLAR 8'h24, DOT 8'h2E, STAR 8'h2A, SPACE 8'h20.
- Sub-module `sme_byte_buf` (parameter DEPTH: write port, length counter with saturation, clear, and a combinational read port), instantiated twice. The FSM and timeout logic sit in `sme_driver`.

## Test plan
- **Basic job:** load string "ab cd" (5 B) and pattern "cd", `start` → `isstring` high for 5 cycles carrying 61,62,20,63,64; `ispattern` high for 2 cycles carrying 63,64 with no gap. A model SME returns `valid`, `match`=1, index 3 → `done` with `res_index`=3, `busy` low 2 cycles later, lengths 0.
- **Keep string:** load pattern "ab" only, `start` with `keep_string`=1 → no `isstring` cycles; `ispattern` in cycles t+1,t+2; result captured normally.
- **Timeout:** TIMEOUT=16, model never raises `valid` → `done`=1, `timeout`=1, `res_match`=0 exactly 16 cycles after WAIT entry.
- **Overflow:** 33 string writes and 9 pattern writes → `str_len`=32, `pat_len`=8; the streamed bytes are the first 32 and first 8.
- **Guards:** `start` with `pat_len`=0 → ignored, `busy` stays 0. `ld_en` during busy → lengths unchanged.
- **Reset mid-job:** assert `reset` during SEND_STR → `isstring`, `busy`, `chardata` 0 immediately; after release, a new job runs correctly.
